baugh_wooley_pipe: RTL and testbench
====================================

Name: baugh_wooley_pipe

Overview:
Parametrised, pipelined Baugh-Wooley multiplier. It is the successor to the fixed 8x6 registered multiplier. It adds configurable operand widths, a configurable pipeline depth, a per-transaction signed/unsigned mode, and a valid/ready handshake with full backpressure. It sits in the datapath between operand producers and downstream accumulate/filter blocks.

Parameters:
- A_W, 8: width of operand a; legal range 2..32.
- B_W, 6: width of operand b, which is also the partial-product row count; legal range 2..32.
- STAGES, 3: pipeline register stages; legal range 1..B_W. Rows per stage RPS = ceil(B_W/STAGES).

Ports:
- clk  in  1  clock; all flops on the rising edge.
- rst  in  1  reset, asynchronous, active-low (asserted when 0).
- in_valid  in  1  operand transfer request.
- in_ready  out  1  block can accept operands this cycle.
- a  in  A_W  multiplicand.
- b  in  B_W  multiplier.
- tc_mode  in  1  1 = signed x signed (two's complement); 0 = unsigned x unsigned.
- out_valid  out  1  mult holds a valid product.
- out_ready  in  1  downstream accepts the product.
- mult  out  A_W+B_W  product.

Behaviour:
- Reset (rst=0, asynchronous): all stage valid bits = 0; out_valid = 0; mult = 0; all partial sums = 0. in_ready comes out of reset at 1.
- Handshake:
  - An input transfers on in_valid & in_ready.
  - An output transfers on out_valid & out_ready.
  - out_valid never drops without a transfer.
  - mult is stable while out_valid & !out_ready.
- Stall: stall = out_valid & !out_ready.
  - in_ready = !stall.
  - When stall is high, every stage holds; no bubble squeezing.
  - When stall is low, every stage advances; a stage with no valid input loads valid=0.
- Latency: exactly STAGES cycles from input transfer to out_valid, with no stall. Throughput is 1 product/cycle.
- Stage k (0-based) adds partial-product rows k*RPS .. min((k+1)*RPS, B_W)-1 into the running sum.
  - a, b and tc_mode travel with the sum through the pipeline.
  - The final stage register drives mult.
- Arithmetic, tc_mode=1:
  - Complement the cross terms a[A_W-1]&b[j] (j<B_W-1) and a[i]&b[B_W-1] (i<A_W-1).
  - a[A_W-1]&b[B_W-1] is not complemented.
  - Add the constant 2^(A_W-1) + 2^(B_W-1) + 2^(A_W+B_W-1) in stage 0.
  - All sums are mod 2^(A_W+B_W).
  - Result equals the exact signed product; the full range is representable, e.g. (-2^(A_W-1))*(-2^(B_W-1)) = 2^(A_W+B_W-2) fits.
- Arithmetic, tc_mode=0: plain AND rows, no constant; result equals the exact unsigned product.
- Mode may change on every transfer. Back-to-back transfers with mixed modes are legal and do not interfere.
- Simultaneous output and input transfer in the same cycle: both occur and the pipe advances.
- Reset mid-operation: all in-flight transactions are discarded and none appear after reset release.
- Inputs a, b and tc_mode are ignored when in_valid=0.

Optional Feature:
- Macro: BW_MAC_EN.
- When defined, the block adds three ports:
  - acc_clr (in, 1)
  - acc (out, A_W+B_W+8)
  - acc_valid (out, 1)
- Each output transfer adds mult, sign-extended when its tc_mode=1 and zero-extended otherwise, into acc. acc wraps mod 2^(A_W+B_W+8).
- acc_clr=1 on an output-transfer cycle loads acc with that product.
- acc_clr=1 with no transfer clears acc to 0.
- acc_valid pulses one cycle after each output transfer.
- Reset clears acc to 0 and acc_valid to 0.
- When the macro is undefined, these ports and the logic behind them do not exist, and the core behaviour is unchanged.

Decomposition:
- Package bw_pkg holds:
  - function bw_rows(A_W, B_W, lo, hi, tc), returning the summed partial-product rows lo..hi;
  - function bw_const(A_W, B_W), returning the correction constant;
  - localparam helper ceil_div.
- One sub-module, bw_pipe_stage. It holds one register slice: valid, a, b, tc, sum. Its inputs are stall and the row range. The top instantiates it STAGES times in a generate loop.

Test Plan:
- A_W=8, B_W=6, STAGES=3, tc=1, out_ready=1: (-128,-32) -> 14'h1000; (127,-32) -> 14'h3020; (-9,-32) -> 14'h0120; (-6,-7) -> 14'h002A; (4,-5) -> 14'h3FEC. Each arrives 3 cycles after its transfer.
- tc=0: (255,63) -> 14'h3EC1; (1,1) -> 1. Interleave with tc=1 (-1,-1) -> 1 on alternate cycles; verify per-transaction mode.
- Backpressure: stream 6 operand pairs with out_ready=0 for 4 cycles. Check in_ready=0 during the stall, mult held stable, no loss or duplication, and in-order products.
- Assert rst low for 1 cycle with 3 transactions in flight. Check out_valid=0 and mult=0 immediately (asynchronous), and no stale outputs after release.
- Sweep STAGES in {1, B_W} and widths (A_W, B_W) = (4,4), (16,12). Run random operands against a behavioural signed/unsigned model and check the latency equals STAGES.
- With BW_MAC_EN: products 42, 288, -4064, using acc_clr on the first. Check acc = 42, 330, -3734 sign-extended, and acc_valid pulses one cycle after each transfer.

Source files
------------

// File: rtl/bw_pkg.sv
// Shared helpers for the pipelined Baugh-Wooley multiplier: row summation,
// signed-mode correction constant and ceiling division for rows-per-stage.
package bw_pkg;

  localparam int MAX_W = 32;

  function automatic int ceil_div(input int x, input int y);
    return (x + y - 1) / y;
  endfunction

  // Correction constant for the complemented cross terms (mod 2^(aw+bw) by caller).
  function automatic logic [63:0] bw_const(input int aw, input int bw);
    return (64'd1 << (aw - 1)) + (64'd1 << (bw - 1)) + (64'd1 << (aw + bw - 1));
  endfunction

  // Sum of partial-product rows lo..hi; in signed mode the sign cross terms are inverted.
  function automatic logic [63:0] bw_rows(input int aw, input int bw, input int lo,
                                          input int hi, input logic tc,
                                          input logic [31:0] a, input logic [31:0] b);
    logic [63:0] acc;
    logic        pp;
    acc = '0;
    for (int j = 0; j < MAX_W; j++) begin
      if (j >= lo && j <= hi && j < bw) begin
        for (int i = 0; i < MAX_W; i++) begin
          if (i < aw) begin
            pp = a[i] & b[j];
            if (tc && ((i == aw - 1) != (j == bw - 1)))
              pp = ~pp;
            acc = acc + (64'(pp) << (i + j));
          end
        end
      end
    end
    return acc;
  endfunction

endpackage

// File: rtl/bw_pipe_stage.sv
// One pipeline slice: adds rows LO..HI into the running sum and carries the
// operands and mode forward. Holds everything while stall is high.
module bw_pipe_stage
  import bw_pkg::*;
#(
  parameter int A_W   = 8,
  parameter int B_W   = 6,
  parameter int LO    = 0,
  parameter int HI    = 1,
  parameter bit FIRST = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               prv_valid,
  input  logic [A_W-1:0]     prv_a,
  input  logic [B_W-1:0]     prv_b,
  input  logic               prv_tc,
  input  logic [A_W+B_W-1:0] prv_sum,
  output logic               valid,
  output logic [A_W-1:0]     a,
  output logic [B_W-1:0]     b,
  output logic               tc,
  output logic [A_W+B_W-1:0] sum
);

  localparam int P_W = A_W + B_W;

  logic [P_W-1:0] sum_next;

  always_comb begin
    sum_next = P_W'(64'(prv_sum)
                    + bw_rows(A_W, B_W, LO, HI, prv_tc, 32'(prv_a), 32'(prv_b))
                    + ((FIRST && prv_tc) ? bw_const(A_W, B_W) : 64'd0));
  end

  // Payload only loads with a valid token so mult keeps the last product across bubbles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid <= 1'b0;
      a     <= '0;
      b     <= '0;
      tc    <= 1'b0;
      sum   <= '0;
    end else if (!stall) begin
      valid <= prv_valid;
      if (prv_valid) begin
        a   <= prv_a;
        b   <= prv_b;
        tc  <= prv_tc;
        sum <= sum_next;
      end
    end
  end

endmodule

// File: rtl/baugh_wooley_pipe.sv
// Parametrised pipelined Baugh-Wooley multiplier with valid/ready backpressure.
// Optional accumulator on the output side is enabled by defining BW_MAC_EN.
module baugh_wooley_pipe
  import bw_pkg::*;
#(
  parameter int A_W    = 8,
  parameter int B_W    = 6,
  parameter int STAGES = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [A_W-1:0]     a,
  input  logic [B_W-1:0]     b,
  input  logic               tc_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [A_W+B_W-1:0] mult
`ifdef BW_MAC_EN
  ,
  input  logic               acc_clr,
  output logic [A_W+B_W+7:0] acc,
  output logic               acc_valid
`endif
);

  localparam int P_W = A_W + B_W;
  localparam int RPS = ceil_div(B_W, STAGES);

  logic              stall;
  logic [STAGES:0]   v;
  logic [A_W-1:0]    av [STAGES+1];
  logic [B_W-1:0]    bv [STAGES+1];
  logic              tv [STAGES+1];
  logic [P_W-1:0]    sv [STAGES+1];

  assign stall     = out_valid & ~out_ready;
  assign in_ready  = ~stall;
  assign v[0]      = in_valid;
  assign av[0]     = a;
  assign bv[0]     = b;
  assign tv[0]     = tc_mode;
  assign sv[0]     = '0;
  assign out_valid = v[STAGES];
  assign mult      = sv[STAGES];

  generate
    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
      // Trailing stages may get an empty row range when B_W is not a multiple of STAGES.
      localparam int LO = gi * RPS;
      localparam int HI = (((gi + 1) * RPS < B_W) ? (gi + 1) * RPS : B_W) - 1;

      bw_pipe_stage #(
        .A_W  (A_W),
        .B_W  (B_W),
        .LO   (LO),
        .HI   (HI),
        .FIRST(gi == 0)
      ) u_stage (
        .clk      (clk),
        .rst      (rst),
        .stall    (stall),
        .prv_valid(v[gi]),
        .prv_a    (av[gi]),
        .prv_b    (bv[gi]),
        .prv_tc   (tv[gi]),
        .prv_sum  (sv[gi]),
        .valid    (v[gi+1]),
        .a        (av[gi+1]),
        .b        (bv[gi+1]),
        .tc       (tv[gi+1]),
        .sum      (sv[gi+1])
      );
    end
  endgenerate

`ifdef BW_MAC_EN
  logic           out_xfer;
  logic [P_W+7:0] ext;

  assign out_xfer = out_valid & out_ready;
  assign ext      = tv[STAGES] ? {{8{mult[P_W-1]}}, mult} : {8'd0, mult};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc       <= '0;
      acc_valid <= 1'b0;
    end else begin
      acc_valid <= out_xfer;
      if (out_xfer)
        acc <= acc_clr ? ext : acc + ext;
      else if (acc_clr)
        acc <= '0;
    end
  end
`endif

endmodule

// File: tb/tb_baugh_wooley_pipe.sv
// Randomised and directed bench for baugh_wooley_pipe against an arithmetic reference.
// Covers the BW_MAC_EN accumulator when that macro is defined.
module tb_baugh_wooley_pipe;

  localparam int AW = 8, BW = 6, ST = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        in_valid, in_ready, tc_mode, out_valid, out_ready;
  logic [7:0]  a;
  logic [5:0]  b;
  logic [13:0] mult;
`ifdef BW_MAC_EN
  logic        acc_clr;
  logic [21:0] acc;
  logic        acc_valid;
`endif

  // Secondary configurations: narrow single-stage and wide fully-pipelined.
  logic        v2, r2, t2, ov2, v3, r3, t3, ov3;
  logic        ordy_x;
  logic [3:0]  a2, b2;
  logic [7:0]  m2;
  logic [15:0] a3;
  logic [11:0] b3;
  logic [27:0] m3;

  int checks = 0;
  int errors = 0;
  longint exp_q[$];

  baugh_wooley_pipe #(.A_W(AW), .B_W(BW), .STAGES(ST)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .tc_mode(tc_mode), .out_valid(out_valid), .out_ready(out_ready), .mult(mult)
`ifdef BW_MAC_EN
    , .acc_clr(acc_clr), .acc(acc), .acc_valid(acc_valid)
`endif
  );

  baugh_wooley_pipe #(.A_W(4), .B_W(4), .STAGES(1)) dut2 (
    .clk(clk), .rst(rst), .in_valid(v2), .in_ready(r2), .a(a2), .b(b2),
    .tc_mode(t2), .out_valid(ov2), .out_ready(ordy_x), .mult(m2)
`ifdef BW_MAC_EN
    , .acc_clr(1'b0), .acc(), .acc_valid()
`endif
  );

  baugh_wooley_pipe #(.A_W(16), .B_W(12), .STAGES(12)) dut3 (
    .clk(clk), .rst(rst), .in_valid(v3), .in_ready(r3), .a(a3), .b(b3),
    .tc_mode(t3), .out_valid(ov3), .out_ready(ordy_x), .mult(m3)
`ifdef BW_MAC_EN
    , .acc_clr(1'b0), .acc(), .acc_valid()
`endif
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Exact product from integer arithmetic, reduced mod 2^(aw+bw).
  function automatic longint ref_mult(input longint x, input longint y, input bit tc,
                                      input int aw, input int bw);
    longint sx = x;
    longint sy = y;
    if (tc && x[aw-1]) sx = x - (longint'(1) << aw);
    if (tc && y[bw-1]) sy = y - (longint'(1) << bw);
    return (sx * sy) & ((longint'(1) << (aw + bw)) - 1);
  endfunction

  // Inputs change 2ns after the rising edge; handshake is sampled at the falling edge.
  task automatic drive(input bit iv, input logic [7:0] av, input logic [5:0] bv, input bit tc,
                       input longint e, input bit ordy, output bit ok);
    in_valid  = iv;
    a         = av;
    b         = bv;
    tc_mode   = tc;
    out_ready = ordy;
    @(negedge clk);
    ok = iv && in_ready;
    if (ok) exp_q.push_back(e);
    @(posedge clk);
    #2;
  endtask

  // Output scoreboard, stall behaviour and hold checks on the main instance.
  logic        stall_prev = 1'b0;
  logic [13:0] mult_prev  = '0;
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (stall_prev) begin
        check_val("hold_mult", mult, mult_prev);
        check_val("hold_valid", out_valid, 1);
      end
      if (out_valid && !out_ready) check_val("in_ready_stall", in_ready, 0);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check_val("extra_out", out_valid, 0);
        else check_val("product", mult, exp_q.pop_front());
      end
      stall_prev = out_valid && !out_ready;
      mult_prev  = mult;
    end else begin
      stall_prev = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin : main
    bit ok;
    int idx, cyc;
    logic [7:0] sa [6];
    logic [5:0] sb [6];
    logic       st [6];
    logic [7:0] ra;
    logic [5:0] rb;
    logic       rt;
    logic [7:0] d_a [5] = '{8'h80, 8'h7f, 8'hf7, 8'hfa, 8'h04};
    logic [5:0] d_b [5] = '{6'h20, 6'h20, 6'h20, 6'h39, 6'h3b};
    longint     d_e [5] = '{64'h1000, 64'h3020, 64'h0120, 64'h002A, 64'h3FEC};
    logic [7:0] m_a [6] = '{8'hff, 8'hff, 8'h01, 8'hff, 8'hff, 8'h80};
    logic [5:0] m_b [6] = '{6'h3f, 6'h3f, 6'h01, 6'h3f, 6'h3f, 6'h20};
    bit         m_t [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    longint     m_e [6] = '{64'h3EC1, 64'h1, 64'h1, 64'h1, 64'h3EC1, 64'h1000};
    longint     e2 [100], e3 [100];
    bit         q2 [100], q3 [100];

    rst = 1'b0; in_valid = 0; a = 0; b = 0; tc_mode = 0; out_ready = 1;
    v2 = 0; a2 = 0; b2 = 0; t2 = 0; v3 = 0; a3 = 0; b3 = 0; t3 = 0; ordy_x = 1;
`ifdef BW_MAC_EN
    acc_clr = 0;
`endif
    #3;
    check_val("rst_out_valid", out_valid, 0);
    check_val("rst_mult", mult, 0);
    check_val("rst_in_ready", in_ready, 1);
    @(posedge clk); @(posedge clk); #2;
    rst = 1'b1;
    @(posedge clk); #2;

    // Signed directed vectors, each followed by an exact latency check.
    for (int i = 0; i < 5; i++) begin
      drive(1, d_a[i], d_b[i], 1, d_e[i], 1, ok);
      check_val("accept", ok, 1);
      for (int k = 0; k < ST; k++) begin
        check_val("latency", out_valid, (k == ST - 1));
        if (k < ST - 1) drive(0, 0, 0, 0, 0, 1, ok);
      end
    end

    // Back-to-back transfers alternating modes.
    for (int i = 0; i < 6; i++) begin
      drive(1, m_a[i], m_b[i], m_t[i], m_e[i], 1, ok);
      check_val("mixed_accept", ok, 1);
    end
    for (int i = 0; i < ST + 2; i++) drive(0, 0, 0, 0, 0, 1, ok);
    check_val("mixed_drain", exp_q.size(), 0);

    // Six pairs streamed while the sink stalls for four cycles.
    for (int i = 0; i < 6; i++) begin
      sa[i] = 8'($urandom); sb[i] = 6'($urandom); st[i] = 1'($urandom);
    end
    idx = 0;
    for (int c = 0; c < 40 && (idx < 6 || c < 8); c++) begin
      if (idx < 6)
        drive(1, sa[idx], sb[idx], st[idx], ref_mult(sa[idx], sb[idx], st[idx], AW, BW),
              !(c >= 3 && c < 7), ok);
      else
        drive(0, 0, 0, 0, 0, !(c >= 3 && c < 7), ok);
      if (ok) idx++;
    end
    check_val("bp_all_sent", idx, 6);
    for (int i = 0; i < ST + 2; i++) drive(0, 0, 0, 0, 0, 1, ok);
    check_val("bp_drain", exp_q.size(), 0);

    // Random traffic with random backpressure.
    idx = 0; cyc = 0;
    ra = 8'($urandom); rb = 6'($urandom); rt = 1'($urandom);
    while (idx < 150 && cyc < 2000) begin
      drive(($urandom_range(3, 0) != 0), ra, rb, rt, ref_mult(ra, rb, rt, AW, BW),
            ($urandom_range(3, 0) != 0), ok);
      if (ok) begin
        idx++;
        ra = 8'($urandom); rb = 6'($urandom); rt = 1'($urandom);
      end
      cyc++;
    end
    check_val("rand_all_sent", idx, 150);
    for (int i = 0; i < ST + 2; i++) drive(0, 0, 0, 0, 0, 1, ok);
    check_val("rand_drain", exp_q.size(), 0);

    // Reset with three transactions in flight.
    for (int i = 0; i < 3; i++) drive(1, 8'(i + 3), 6'(i + 5), 1, ref_mult(i + 3, i + 5, 1, AW, BW), 1, ok);
    in_valid = 0;
    #1 rst = 1'b0;
    #1;
    check_val("async_rst_valid", out_valid, 0);
    check_val("async_rst_mult", mult, 0);
    exp_q.delete();
    @(posedge clk); #2;
    rst = 1'b1;
    for (int i = 0; i < ST + 3; i++) begin
      drive(0, 0, 0, 0, 0, 1, ok);
      check_val("post_rst_idle", out_valid, 0);
    end

`ifdef BW_MAC_EN
    begin : mac
      int n;
      bit xf;
      longint accm;
      longint prods [3];
      prods = '{42, 288, -4064};
      drive(1, 8'd6, 6'd7, 1, ref_mult(6, 7, 1, AW, BW), 1, ok);
      drive(1, 8'hf7, 6'h20, 1, ref_mult(8'hf7, 6'h20, 1, AW, BW), 1, ok);
      drive(1, 8'h7f, 6'h20, 1, ref_mult(8'h7f, 6'h20, 1, AW, BW), 1, ok);
      in_valid = 0;
      n = 0; accm = 0;
      for (int c = 0; c < 8; c++) begin
        @(negedge clk);
        xf = out_valid;
        acc_clr = xf && (n == 0);
        @(posedge clk); #2;
        acc_clr = 0;
        check_val("acc_valid", acc_valid, xf);
        if (xf && n < 3) begin
          accm = (n == 0) ? prods[n] : accm + prods[n];
          check_val("acc", acc, accm & 64'h3FFFFF);
          n++;
        end
      end
      check_val("mac_count", n, 3);
      acc_clr = 1;
      @(posedge clk); #2;
      acc_clr = 0;
      check_val("acc_clear_idle", acc, 0);
    end
`endif

    // Width/depth sweep: outputs must appear exactly STAGES cycles after input.
    for (int c = 0; c < 90; c++) begin
      v2 = (c < 70) && ($urandom_range(3, 0) != 0);
      a2 = 4'($urandom); b2 = 4'($urandom); t2 = 1'($urandom);
      v3 = (c < 70) && ($urandom_range(3, 0) != 0);
      a3 = 16'($urandom); b3 = 12'($urandom); t3 = 1'($urandom);
      q2[c] = v2; e2[c] = ref_mult(a2, b2, t2, 4, 4);
      q3[c] = v3; e3[c] = ref_mult(a3, b3, t3, 16, 12);
      @(negedge clk);
      check_val("w4_ready", r2, 1);
      check_val("w16_ready", r3, 1);
      check_val("w4_valid", ov2, (c >= 1) ? q2[c - 1] : 1'b0);
      if (c >= 1 && q2[c - 1]) check_val("w4_mult", m2, e2[c - 1]);
      check_val("w16_valid", ov3, (c >= 12) ? q3[c - 12] : 1'b0);
      if (c >= 12 && q3[c - 12]) check_val("w16_mult", m3, e3[c - 12]);
      @(posedge clk); #2;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
